// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// It consumes one input bit per clock. A WIDTH-bit unsigned value becomes
// DIGITS packed BCD digits. A registered leading-zero blanking mask and an
// overflow flag are produced alongside the digits.
//
// Ports:
//   clk      system clock, rising-edge active
//   rst      asynchronous, active-high reset
//   start    conversion request, only looked at while idle
//   a        binary value, captured on the edge that accepts start
//   busy     high while a conversion is running
//   done     one-cycle pulse when bcd/blank/overflow take a new result
//   bcd      packed result, digit i in bits [4i+3:4i], digit 0 = ones
//   blank    leading-zero mask, bit i = 1 means digit i should be dark
//   overflow value needed more than DIGITS digits; bcd holds the low digits
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH);

  // Every digit except the ones digit is blanked, so an idle display shows "0".
  localparam logic [DIGITS-1:0] BLANK_RESET = ~DIGITS'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state;
  state_t              nextState;

  logic [CW-1:0]       bitCount;
  logic [WIDTH-1:0]    shiftReg;
  logic [4*DIGITS-1:0] scratch;
  logic                ovScratch;

  logic [4*DIGITS-1:0] adjusted;
  logic [4*DIGITS-1:0] shiftedScratch;
  logic                outBit;
  logic                finalOv;
  logic                lastStep;
  logic [DIGITS-1:0]   mask;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. A start request that arrives while busy is dropped,
  // not queued. The last shift step returns to IDLE, so a start that is
  // present during the done cycle is accepted on the next edge.
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (lastStep) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign lastStep = (state == SHIFT) && (bitCount == CW'(WIDTH - 1));

  // Add 3 to every digit that is 5 or more. This happens before the shift,
  // so the digit carries correctly into its neighbour once doubled. Each
  // digit is adjusted on its own, with no carry between digits.
  always_comb begin
    logic [3:0] digit;
    adjusted = '0;
    digit    = '0;
    for (int d = 0; d < DIGITS; d++) begin
      digit = scratch[4*d +: 4];
      adjusted[4*d +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
  end

  // The bit that leaves the top digit is a carry into a digit we do not have.
  // Any such bit means the value does not fit.
  assign shiftedScratch = {adjusted[4*DIGITS-2:0], shiftReg[WIDTH-1]};
  assign outBit         = adjusted[4*DIGITS-1];
  assign finalOv        = ovScratch | outBit;

  // Blanking mask for the result about to be published. Scan from the top
  // digit down, and keep blanking while every digit seen so far is zero.
  // The ones digit always stays lit. An overflowed result is shown in full,
  // because its high digits are not real leading zeros.
  always_comb begin
    logic allZero;
    mask    = '0;
    allZero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allZero = allZero & (shiftedScratch[4*i +: 4] == 4'd0);
      mask[i] = allZero;
    end
    mask[0] = 1'b0;
    if (finalOv) begin
      mask = '0;
    end
  end

  // Datapath and output registers. The published outputs change only on
  // the final step, so downstream logic never sees partial scratch values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitCount  <= '0;
      shiftReg  <= '0;
      scratch   <= '0;
      ovScratch <= 1'b0;
      bcd       <= '0;
      blank     <= BLANK_RESET;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shiftReg  <= a;
            scratch   <= '0;
            ovScratch <= 1'b0;
            bitCount  <= '0;
          end
        end
        SHIFT: begin
          shiftReg  <= {shiftReg[WIDTH-2:0], 1'b0};
          scratch   <= shiftedScratch;
          ovScratch <= finalOv;
          bitCount  <= bitCount + CW'(1);
          if (lastStep) begin
            bitCount <= '0;
            bcd      <= shiftedScratch;
            overflow <= finalOv;
            blank    <= mask;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
//
// Self-checking bench for bin2bcd_seq. It uses two instances: a 16-bit /
// 5-digit converter and an 8-bit / 2-digit converter. Expected results come
// from a decimal reference model that uses plain arithmetic: repeated
// divide-by-10, a power-of-ten overflow test and a significant-digit count
// for blanking.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;

  logic        start16;
  logic [15:0] a16;
  logic        busy16;
  logic        done16;
  logic [19:0] bcd16;
  logic [4:0]  blank16;
  logic        overflow16;

  logic        start8;
  logic [7:0]  a8;
  logic        busy8;
  logic        done8;
  logic [7:0]  bcd8;
  logic [1:0]  blank8;
  logic        overflow8;

  int          total;
  int          bad;
  logic [63:0] prev16;
  logic [63:0] prev8;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clk      (clk),
    .rst      (rst),
    .start    (start16),
    .a        (a16),
    .busy     (busy16),
    .done     (done16),
    .bcd      (bcd16),
    .blank    (blank16),
    .overflow (overflow16)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .a        (a8),
    .busy     (busy8),
    .done     (done8),
    .bcd      (bcd8),
    .blank    (blank8),
    .overflow (overflow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: low-order decimal digits of the value, packed as BCD.
  function automatic logic [63:0] refBcd(input longint val, input int nd);
    logic [63:0] r;
    longint      v;
    r = '0;
    v = val;
    for (int i = 0; i < nd; i++) begin
      r = r | (64'(v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  // Reference model: the value needs more than nd decimal digits.
  function automatic logic refOv(input longint val, input int nd);
    longint p;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    return (val >= p);
  endfunction

  // Reference model: blank every digit position above the value's
  // significant digits. Zero still has one significant digit.
  function automatic logic [63:0] refBlank(input longint val, input int nd);
    logic [63:0] m;
    int          sig;
    longint      v;
    if (refOv(val, nd)) return '0;
    sig = 0;
    v   = val;
    do begin
      sig++;
      v = v / 10;
    end while (v != 0);
    m = '0;
    for (int i = 0; i < nd; i++) begin
      if (i >= sig) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Run one conversion on the selected instance (sel=1 selects the 8-bit
  // one). Check the latency, that the outputs hold until done, the result,
  // and that done lasts a single cycle.
  task automatic applyStimulus(input bit sel, input longint val);
    int          nd;
    int          w;
    int          edges;
    bit          seen;
    logic [63:0] prev;
    nd   = sel ? 2 : 5;
    w    = sel ? 8 : 16;
    prev = sel ? prev8 : prev16;
    @(negedge clk);
    if (sel) begin
      a8 = 8'(val);
      start8 = 1'b1;
    end else begin
      a16 = 16'(val);
      start16 = 1'b1;
    end
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      @(negedge clk);
      edges++;
      start8  = 1'b0;
      start16 = 1'b0;
      if (edges == 1) checkOutput("busy_after_accept", sel ? busy8 : busy16, 1);
      if (sel ? done8 : done16) begin
        seen = 1'b1;
      end else begin
        checkOutput("bcd_hold", sel ? 64'(bcd8) : 64'(bcd16), prev);
      end
    end
    checkOutput("latency", 64'(edges), 64'(w + 1));
    checkOutput("bcd", sel ? 64'(bcd8) : 64'(bcd16), refBcd(val, nd));
    checkOutput("blank", sel ? 64'(blank8) : 64'(blank16), refBlank(val, nd));
    checkOutput("overflow", sel ? overflow8 : overflow16, refOv(val, nd));
    checkOutput("busy_at_done", sel ? busy8 : busy16, 0);
    if (sel) prev8 = refBcd(val, nd);
    else     prev16 = refBcd(val, nd);
    @(negedge clk);
    checkOutput("done_one_cycle", sel ? done8 : done16, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy16"}, busy16, 0);
    checkOutput({tag, "_done16"}, done16, 0);
    checkOutput({tag, "_bcd16"}, 64'(bcd16), 0);
    checkOutput({tag, "_ovf16"}, overflow16, 0);
    checkOutput({tag, "_blank16"}, 64'(blank16), 64'b11110);
    checkOutput({tag, "_busy8"}, busy8, 0);
    checkOutput({tag, "_bcd8"}, 64'(bcd8), 0);
    checkOutput({tag, "_blank8"}, 64'(blank8), 64'b10);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          vals[4];
    int          idx;
    int          gap;
    int          dones;
    logic [63:0] exp;

    total   = 0;
    bad     = 0;
    prev16  = '0;
    prev8   = '0;
    rst     = 1'b1;
    start16 = 1'b0;
    start8  = 1'b0;
    a16     = '0;
    a8      = '0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;

    // Directed values for the 16-bit instance.
    applyStimulus(1'b0, 0);
    applyStimulus(1'b0, 1234);
    applyStimulus(1'b0, 65535);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, longint'($urandom_range(0, 65535)));

    // Hold start high. Results arrive every 17 cycles, with no idle gap.
    vals = '{20, 40, 128, 255};
    @(negedge clk);
    a16     = 16'(vals[0]);
    start16 = 1'b1;
    idx     = 0;
    gap     = 0;
    for (int c = 0; c < 200 && idx < 4; c++) begin
      @(negedge clk);
      gap++;
      if (done16) begin
        exp = refBcd(vals[idx], 5);
        checkOutput("cont_bcd", 64'(bcd16), exp);
        checkOutput("cont_spacing", 64'(gap), 17);
        prev16 = exp;
        gap    = 0;
        idx++;
        if (idx < 4) a16 = 16'(vals[idx]);
        else start16 = 1'b0;
      end else begin
        checkOutput("cont_hold", 64'(bcd16), prev16);
      end
    end
    checkOutput("cont_count", 64'(idx), 4);
    start16 = 1'b0;
    repeat (2) @(negedge clk);

    // A start during a conversion is ignored.
    @(negedge clk);
    a16     = 16'd9999;
    start16 = 1'b1;
    dones   = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (c == 5) begin
        a16     = 16'd7;
        start16 = 1'b1;
      end
      if (done16) begin
        dones++;
        checkOutput("ignore_latency", 64'(c), 17);
        checkOutput("ignore_bcd", 64'(bcd16), 64'h09999);
      end
    end
    start16 = 1'b0;
    checkOutput("ignore_done_count", 64'(dones), 1);
    prev16 = 64'h09999;

    // Reset during a conversion aborts it. The outputs clear at once.
    @(negedge clk);
    a16     = 16'd12345;
    start16 = 1'b1;
    repeat (8) begin
      @(negedge clk);
      start16 = 1'b0;
    end
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    @(negedge clk);
    rst    = 1'b0;
    prev16 = '0;
    prev8  = '0;
    dones  = 0;
    repeat (30) begin
      @(negedge clk);
      if (done16) dones++;
    end
    checkOutput("midrst_no_done", 64'(dones), 0);
    applyStimulus(1'b0, 42);

    // Narrow instance: boundary values, overflow and random values.
    applyStimulus(1'b1, 99);
    applyStimulus(1'b1, 255);
    applyStimulus(1'b1, 100);
    applyStimulus(1'b1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, longint'($urandom_range(0, 255)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, sequential binary-to-BCD converter using shift-and-add-3 (double-dabble), one input bit per clock. It converts a WIDTH-bit unsigned value into DIGITS packed BCD digits. It also provides a registered leading-zero blanking mask and an overflow flag. It sits between counter/arithmetic logic and the LED digit multiplexer, replacing the fixed 8-bit combinational converter wherever wider values or registered, glitch-free display data are needed.

## Interface
- WIDTH, 16, bit width of the binary input; legal range 4..32.
- DIGITS, 5, number of BCD output digits; legal range 1..10. DIGITS need not cover 2^WIDTH-1; OVERFLOW reports when it does not.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  conversion request; sampled only in IDLE.
- A  input  WIDTH  unsigned binary value; sampled on the edge that accepts START.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when BCD/BLANK/OVERFLOW update.
- BCD  output  4*DIGITS  packed result; digit i occupies bits [4i+3:4i], digit 0 is the ones digit.
- BLANK  output  DIGITS  leading-zero mask; bit i=1 means digit i should be blanked.
- OVERFLOW  output  1  value did not fit in DIGITS digits; BCD is then the low-order digits only.

## Operation
- Two states:
  - IDLE: BUSY=0.
  - SHIFT: BUSY=1. A bit counter runs 0..WIDTH-1.
- IDLE with START=1: latch A into the shift register, clear the BCD scratch register, clear the overflow scratch, then go to SHIFT.
- Each SHIFT cycle:
  - Every scratch digit that is ≥5 has 3 added (4-bit, no carry between digits).
  - The concatenation {scratch, shift} is then shifted left by one; the MSB of the shift register enters digit 0 bit 0.
- Bit shifted out of the top digit = 1 sets the overflow scratch (sticky for that conversion).
- On the last SHIFT cycle (counter = WIDTH-1), the following are loaded on the same edge, and the block returns to IDLE:
  - the final scratch value into BCD;
  - the overflow scratch into OVERFLOW;
  - the computed mask into BLANK.
- BLANK rules:
  - bit i=1 iff digit i and all higher digits are zero;
  - bit 0 is always 0, so zero displays "0";
  - when OVERFLOW=1, BLANK is all zeros.
- BCD, BLANK and OVERFLOW hold their values between conversions and never show intermediate scratch values.
- START while BUSY=1 is ignored; it is not queued.
- A may change freely after the accepting edge.

## Timing
- Reset values: BUSY=0, DONE=0, BCD=0, OVERFLOW=0, BLANK = all ones except bit 0. State is IDLE and the counter is 0.
- RST asserted mid-conversion: the conversion is aborted, all outputs go to reset values immediately, and DONE does not pulse.
- START sampled high at edge k (in IDLE):
  - BUSY=1 from edge k through edge k+WIDTH.
  - WIDTH shift steps occur on edges k+1..k+WIDTH.
  - Outputs update and DONE=1 after edge k+WIDTH.
  - BUSY=0 after edge k+WIDTH.
- Latency: WIDTH+1 edges from accepting START to DONE. Throughput: one conversion per WIDTH+1 cycles.
- DONE is high for exactly one cycle.
- START held high (or asserted) during the DONE cycle is accepted at the next edge, because the state is IDLE. Back-to-back conversions therefore need no idle gap.
- Continuous START gives DONE pulses spaced WIDTH+1 cycles apart.

## Test plan
- WIDTH=16, DIGITS=5, A=0, START pulse -> DONE exactly 17 edges after acceptance; BCD=0x00000, BLANK=5'b11110, OVERFLOW=0.
- A=1234 -> BCD=0x01234, BLANK=5'b10000. Then A=65535 -> BCD=0x65535, BLANK=5'b00000.
- START held high continuously with A stepping through 20, 40, 128, 255 -> DONE every 17 cycles; BCD=0x00020, 0x00040, 0x00128, 0x00255 in order; BCD never changes except on DONE cycles.
- START pulsed at cycle 5 of a conversion of 9999, with A=7 -> ignored; result is 0x09999 and exactly one DONE pulse occurs.
- RST asserted at cycle 8 of a conversion -> BUSY/DONE/BCD/OVERFLOW=0 and BLANK=5'b11110 immediately, with no DONE. A subsequent conversion of 42 -> 0x00042.
- Second instance WIDTH=8, DIGITS=2: A=99 -> BCD=0x99, OVERFLOW=0; A=255 -> OVERFLOW=1, BCD=0x55, BLANK=2'b00; DONE 9 edges after acceptance.
